pattern_edit_controller: RTL and testbench

PATTERN_EDIT_CONTROLLER -- requirements
Module: pattern_edit_controller

---
 rtl/pattern_edit_controller.sv | 153 +++++++++++++++
 tb/tb_pattern_edit_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_edit_controller.sv
// Pattern-grid cell editor: read-modify-write of the cell under the cursor,
// sharing a single-port pattern RAM with a playback reader that has priority in IDLE.
module pattern_edit_controller #(
   parameter int unsigned COLS   = 80,
   parameter int unsigned ROWS   = 30,
   parameter int unsigned RD_LAT = 1
) (
   input  logic        clk,
   input  logic        Reset,
   input  logic [1:0]  user_edit,
   input  logic [6:0]  cursor_x,
   input  logic [6:0]  cursor_y,
   input  logic        pb_req,
   input  logic [11:0] pb_addr,
   output logic        pb_gnt,
   output logic        pb_rvalid,
   output logic [7:0]  pb_rdata,
   output logic [11:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_wdata,
   input  logic [7:0]  ram_rdata,
   output logic        busy,
   output logic        edit_done
);

   localparam int unsigned AW = 12;
   localparam int unsigned DW = 8;
   localparam int unsigned CW = 2;

   localparam logic [1:0] CMD_NONE = 2'b00;
   localparam logic [1:0] CMD_INC  = 2'b01;
   localparam logic [1:0] CMD_DEC  = 2'b10;
   localparam logic [1:0] CMD_DEL  = 2'b11;

   typedef enum logic [2:0] {IDLE, RD, WAIT, WR, HOLD} state_t;

   state_t          state, state_n;
   logic            armed, armed_n;
   logic [1:0]      cmd, cmd_n;
   logic [AW-1:0]   edit_addr, edit_addr_n;
   logic [CW-1:0]   cnt, cnt_n;
   logic [AW-1:0]   ram_addr_n;
   logic            ram_we_n, edit_done_n, pb_gnt_n, busy_n;
   logic [DW-1:0]   ram_wdata_n;
   logic [RD_LAT-1:0] rv_q;

   logic [AW-1:0]   cur_addr_c;
   logic            in_range_c;

   assign cur_addr_c = AW'(cursor_y) * AW'(COLS) + AW'(cursor_x);
   assign in_range_c = (32'(cursor_x) < COLS) && (32'(cursor_y) < ROWS);

   // Cell update rule; 00 is the empty cell, decrement floors at 01
   function automatic logic [DW-1:0] new_val(input logic [1:0] c, input logic [DW-1:0] d);
      logic [DW-1:0] r;
      r = d;
      unique case (c)
         CMD_INC:  r = (d == 8'hFF) ? d : d + 8'd1;
         CMD_DEC:  r = (d <= 8'h01) ? d : d - 8'd1;
         CMD_DEL:  r = 8'h00;
         default:  r = d;
      endcase
      return r;
   endfunction

   // Next-state and next-output logic
   always_comb begin
      state_n     = state;
      armed_n     = (user_edit == CMD_NONE) ? 1'b1 : armed;
      cmd_n       = cmd;
      edit_addr_n = edit_addr;
      cnt_n       = cnt;
      ram_addr_n  = ram_addr;
      ram_we_n    = 1'b0;
      ram_wdata_n = '0;
      edit_done_n = 1'b0;
      pb_gnt_n    = 1'b0;

      unique case (state)
         IDLE: begin
            if (pb_req) begin
               pb_gnt_n   = 1'b1;
               ram_addr_n = pb_addr;
            end else if (user_edit != CMD_NONE && armed) begin
               armed_n = 1'b0;
               if (in_range_c) begin
                  cmd_n       = user_edit;
                  edit_addr_n = cur_addr_c;
                  ram_addr_n  = cur_addr_c;
                  state_n     = RD;
               end
            end
         end
         RD: begin
            cnt_n   = '0;
            state_n = WAIT;
         end
         WAIT: begin
            // Read data is valid in the last WAIT cycle; the write is launched from it
            if (cnt == CW'(RD_LAT - 1)) begin
               ram_we_n    = 1'b1;
               ram_wdata_n = new_val(cmd, ram_rdata);
               edit_done_n = 1'b1;
               state_n     = WR;
            end else begin
               cnt_n = cnt + CW'(1);
            end
         end
         WR:      state_n = HOLD;
         HOLD:    state_n = IDLE;
         default: state_n = IDLE;
      endcase

      busy_n = (state_n != IDLE);
   end

   // State and output registers
   always_ff @(posedge clk) begin
      if (Reset) begin
         state     <= IDLE;
         armed     <= 1'b1;
         cmd       <= CMD_NONE;
         edit_addr <= '0;
         cnt       <= '0;
         ram_addr  <= '0;
         ram_we    <= 1'b0;
         ram_wdata <= '0;
         edit_done <= 1'b0;
         pb_gnt    <= 1'b0;
         busy      <= 1'b0;
         rv_q      <= '0;
      end else begin
         state     <= state_n;
         armed     <= armed_n;
         cmd       <= cmd_n;
         edit_addr <= edit_addr_n;
         cnt       <= cnt_n;
         ram_addr  <= ram_addr_n;
         ram_we    <= ram_we_n;
         ram_wdata <= ram_wdata_n;
         edit_done <= edit_done_n;
         pb_gnt    <= pb_gnt_n;
         busy      <= busy_n;
         rv_q[0]   <= pb_gnt;
         for (int i = 1; i < int'(RD_LAT); i++) rv_q[i] <= rv_q[i-1];
      end
   end

   // Playback data passes straight through, gated so it aligns with pb_rvalid
   assign pb_rvalid = rv_q[RD_LAT-1];
   assign pb_rdata  = pb_rvalid ? ram_rdata : '0;

endmodule

// File: tb/tb_pattern_edit_controller.sv
// Scoreboard bench for pattern_edit_controller: RAM model, expected-write and
// expected-playback queues checked by a negedge monitor.
module tb_pattern_edit_controller;
   localparam int RD_LAT = 1;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic [1:0]  user_edit = 2'b00;
   logic [6:0]  cursor_x = '0, cursor_y = '0;
   logic        pb_req = 1'b0;
   logic [11:0] pb_addr = '0;
   logic        pb_gnt, pb_rvalid, ram_we, busy, edit_done;
   logic [7:0]  pb_rdata, ram_wdata, ram_rdata;
   logic [11:0] ram_addr;

   logic        pre_en = 1'b0;
   logic [11:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   logic [7:0]  mem [0:4095];
   logic [7:0]  rd_pipe [RD_LAT];

   typedef struct { logic [11:0] a; logic [7:0] d; } wr_t;
   wr_t         exp_wr[$];
   logic [7:0]  exp_rd[$];
   int          gq[$];
   int          cyc = 0, errors = 0, checks = 0, done_cnt = 0, wr_pushed = 0;

   pattern_edit_controller #(.COLS(80), .ROWS(30), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .Reset(Reset), .user_edit(user_edit), .cursor_x(cursor_x),
      .cursor_y(cursor_y), .pb_req(pb_req), .pb_addr(pb_addr), .pb_gnt(pb_gnt),
      .pb_rvalid(pb_rvalid), .pb_rdata(pb_rdata), .ram_addr(ram_addr),
      .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
      .busy(busy), .edit_done(edit_done));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Pattern RAM: data for an address appears RD_LAT cycles after it is presented
   always @(posedge clk) begin
      if (pre_en) mem[pre_addr] <= pre_data;
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_pipe[0] <= mem[ram_addr];
      for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
   end
   assign ram_rdata = rd_pipe[RD_LAT-1];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: pops the scoreboards whenever the DUT writes or returns playback data
   always @(negedge clk) begin
      if (pb_gnt === 1'b1) begin
         chk("gnt_while_busy", 32'(busy), 32'd0);
         if (!Reset) gq.push_back(cyc);
      end
      if (Reset) gq.delete();
      if (ram_we === 1'b1 || edit_done === 1'b1) begin
         if (edit_done === 1'b1) done_cnt++;
         if (exp_wr.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_write: addr %0d data %0h (cycle %0d)", ram_addr, ram_wdata, cyc);
         end else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("wr_addr", 32'(ram_addr), 32'(w.a));
            chk("wr_data", 32'(ram_wdata), 32'(w.d));
            chk("wr_done_with_we", 32'({ram_we, edit_done}), 32'd3);
         end
      end
      if (pb_rvalid === 1'b1) begin
         if (exp_rd.size() == 0 || gq.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rvalid: data %0h (cycle %0d)", pb_rdata, cyc);
         end else begin
            chk("pb_rdata", 32'(pb_rdata), 32'(exp_rd.pop_front()));
            chk("pb_rvalid_latency", 32'(cyc - gq.pop_front()), 32'(RD_LAT));
         end
      end
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic preload(input logic [11:0] a, input logic [7:0] d);
      pre_addr = a; pre_data = d; pre_en = 1'b1;
      step();
      pre_en = 1'b0;
   endtask

   task automatic exp_write(input logic [11:0] a, input logic [7:0] d);
      wr_t w;
      w.a = a; w.d = d;
      exp_wr.push_back(w);
      wr_pushed++;
   endtask

   task automatic check_reset_outputs(input string tag);
      @(negedge clk);
      chk({tag, "_busy"},      32'(busy), 0);
      chk({tag, "_edit_done"}, 32'(edit_done), 0);
      chk({tag, "_pb_gnt"},    32'(pb_gnt), 0);
      chk({tag, "_pb_rvalid"}, 32'(pb_rvalid), 0);
      chk({tag, "_ram_we"},    32'(ram_we), 0);
      chk({tag, "_ram_addr"},  32'(ram_addr), 0);
      chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
      chk({tag, "_pb_rdata"},  32'(pb_rdata), 0);
      @(posedge clk); #1;
   endtask

   // Hold a command for n cycles counting busy cycles, then release for two cycles
   task automatic press(input int x, input int y, input logic [1:0] c, input int n,
                        output int bc);
      cursor_x = 7'(x); cursor_y = 7'(y); user_edit = c;
      bc = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (busy) bc++;
         @(posedge clk); #1;
      end
      user_edit = 2'b00;
      step(); step();
   endtask

   initial begin
      int bc, n;
      step(); step();
      check_reset_outputs("reset");
      Reset = 1'b0;
      preload(12'd163, 8'h05); preload(12'd0, 8'hFF); preload(12'd1, 8'h01);
      preload(12'd2, 8'h00);   preload(12'd4, 8'h7A); preload(12'd85, 8'h05);
      preload(12'd6, 8'h10);   preload(12'd7, 8'h20); preload(12'd8, 8'h33);
      step();

      // Single increment held 10 cycles: one write, busy for 3+RD_LAT cycles
      exp_write(12'd163, 8'h06);
      press(3, 2, 2'b01, 10, bc);
      chk("busy_cycles", 32'(bc), 32'(3 + RD_LAT));
      chk("done_after_first", 32'(done_cnt), 32'd1);

      // Saturation and delete, each as its own edit
      exp_write(12'd0, 8'hFF); press(0, 0, 2'b01, 10, bc);
      exp_write(12'd1, 8'h01); press(1, 0, 2'b10, 10, bc);
      exp_write(12'd2, 8'h00); press(2, 0, 2'b10, 10, bc);
      exp_write(12'd4, 8'h00); press(4, 0, 2'b11, 10, bc);

      // Press, release, press: two writes 05->06->07
      exp_write(12'd85, 8'h06); press(5, 1, 2'b01, 8, bc);
      exp_write(12'd85, 8'h07); press(5, 1, 2'b01, 8, bc);

      // Out-of-range cursor: dropped, no access
      press(80, 0, 2'b01, 8, bc);
      chk("oob_no_busy", 32'(bc), 32'd0);
      press(0, 30, 2'b11, 8, bc);
      chk("oob_row_no_busy", 32'(bc), 32'd0);

      // Playback and edit in the same cycle: three grants first, RMW right after
      pb_addr = 12'd163; pb_req = 1'b1;
      cursor_x = 7'd6; cursor_y = 7'd0; user_edit = 2'b01;
      repeat (3) exp_rd.push_back(8'h06);
      exp_write(12'd6, 8'h11);
      step(); step(); step();
      @(negedge clk);
      chk("pb_first_gnt", 32'(pb_gnt), 32'd1);
      chk("pb_first_not_busy", 32'(busy), 32'd0);
      pb_req = 1'b0;
      step();
      @(negedge clk);
      chk("rmw_after_pb_busy", 32'(busy), 32'd1);
      chk("rmw_after_pb_no_gnt", 32'(pb_gnt), 32'd0);
      repeat (8) step();
      user_edit = 2'b00; step(); step();

      // Playback raised mid-RMW waits until IDLE; live cursor/cmd changes are ignored
      cursor_x = 7'd7; cursor_y = 7'd0; user_edit = 2'b01;
      exp_write(12'd7, 8'h21);
      exp_rd.push_back(8'h21);
      step();
      cursor_x = 7'd9; cursor_y = 7'd9; user_edit = 2'b11;
      step();
      pb_addr = 12'd7; pb_req = 1'b1;
      n = 0;
      for (int i = 0; i < 20; i++) begin
         step(); n++;
         @(negedge clk);
         if (pb_gnt) break;
      end
      pb_req = 1'b0;
      chk("gnt_delay_after_rmw", 32'(n), 32'(RD_LAT + 3));
      step();
      user_edit = 2'b00;
      repeat (RD_LAT + 3) step();

      // Reset while a playback read is in flight: no pb_rvalid afterwards
      pb_addr = 12'd163; pb_req = 1'b1;
      step();
      pb_req = 1'b0; Reset = 1'b1;
      step();
      Reset = 1'b0;
      repeat (RD_LAT + 2) step();

      // Reset during WAIT: no write, outputs back to reset values, next edit normal
      cursor_x = 7'd8; cursor_y = 7'd0; user_edit = 2'b01;
      step(); step();
      Reset = 1'b1; user_edit = 2'b00;
      step();
      check_reset_outputs("mid_rmw_reset");
      Reset = 1'b0;
      step();
      exp_write(12'd8, 8'h34);
      press(8, 0, 2'b01, 10, bc);
      chk("post_reset_busy_cycles", 32'(bc), 32'(3 + RD_LAT));

      repeat (6) step();
      chk("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      chk("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
      chk("edit_done_total", 32'(done_cnt), 32'(wr_pushed));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete (cycle %0d)", cyc);
      $fatal(1);
   end
endmodule
